i281_datamem_display: RTL and testbench

- Downstream consumer of the i281 toplevel's sixteen data-memory byte outputs (datamem0..datamem15, concatenated into one bus).
- Drives a 4-digit multiplexed seven-segment display: current address, blank, high nibble, low nibble.
- Addresses step manually from a board button or auto-cycle.
- The displayed byte is snapshotted once per scan frame, so the shown value never tears while the CPU writes memory.

---
 rtl/i281_datamem_display.sv | 156 +++++++++++++++
 tb/tb_i281_datamem_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i281_datamem_display.sv
// Purpose: scans a 4-digit seven-segment display showing {addr, blank, hi nibble, lo nibble} of one data-memory byte.
// Latency: an/seg are registered one cycle behind the scan state; addr/byte are snapshotted at each frame boundary.
// Backpressure: none; a pure display consumer that samples datamem_flat only on boundary or load edges.
module i281_datamem_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int DWELL_FRAMES = 250
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] datamem_flat,
  input  logic         auto_mode,
  input  logic         step,
  output logic [3:0]   addr_out,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         frame_tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int WW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL_FRAMES - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    next_addr_q, next_addr_d;
  logic [3:0]    addr_q, addr_d;
  logic [WW-1:0] dwell_q, dwell_d;
  logic [7:0]    snap_q, snap_d;
  logic          step_q;
  logic          load_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick_q, tick_d;

  logic wrap;
  logic boundary;
  logic step_rise;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Next-state for scan counters, address stepping/dwell, snapshot and registered digit drive.
  always_comb begin
    wrap      = (div_q == DIV_LAST);
    boundary  = wrap && (slot_q == 2'd3);
    step_rise = step && !step_q;

    div_d       = wrap ? '0 : div_q + 1'b1;
    slot_d      = wrap ? slot_q + 2'd1 : slot_q;
    next_addr_d = next_addr_q;
    dwell_d     = dwell_q;
    addr_d      = addr_q;
    snap_d      = snap_q;
    tick_d      = boundary;
    an_d        = 4'b1111;
    seg_d       = 7'b1111111;

    if (auto_mode) begin
      // Each address is held for DWELL_FRAMES frames; the increment shows at the following boundary.
      if (boundary) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d     = '0;
          next_addr_d = next_addr_q + 4'd1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
    end else begin
      dwell_d = '0;
      if (step_rise) next_addr_d = next_addr_q + 4'd1;
    end

    // Snapshot uses the pre-increment next_addr so a same-edge step lands one frame later.
    if (boundary || load_q) begin
      addr_d = next_addr_q;
      snap_d = datamem_flat[{next_addr_q, 3'b000} +: 8];
    end

    // Digit drive follows the slot in effect before this edge, so the whole slot sees stable data.
    case (slot_q)
      2'd0: begin
        an_d  = 4'b0111;
        seg_d = hex7(addr_q);
      end
      2'd1: begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
      2'd2: begin
        an_d  = 4'b1101;
        seg_d = hex7(snap_q[7:4]);
      end
      default: begin
        an_d  = 4'b1110;
        seg_d = hex7(snap_q[3:0]);
      end
    endcase
  end

  // State register; reset wins over every other event on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q       <= '0;
      slot_q      <= 2'd0;
      next_addr_q <= 4'd0;
      addr_q      <= 4'd0;
      dwell_q     <= '0;
      snap_q      <= 8'd0;
      step_q      <= 1'b0;
      load_q      <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      tick_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      slot_q      <= slot_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      dwell_q     <= dwell_d;
      snap_q      <= snap_d;
      step_q      <= step;
      load_q      <= 1'b0;
      an_q        <= an_d;
      seg_q       <= seg_d;
      tick_q      <= tick_d;
    end
  end

  assign addr_out   = addr_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_i281_datamem_display.sv
// Bench for i281_datamem_display with SCAN_DIV=4, DWELL_FRAMES=2.
// One table record per clock: inputs applied before the edge, outputs checked 1 time unit after it.
// Frames are expanded into records by add_frame from hand-chosen address/byte/step patterns.
module tb_i281_datamem_display;

  localparam int SD = 4;
  localparam int DF = 2;
  localparam int FL = 4 * SD;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] datamem_flat;
  logic         auto_mode;
  logic         step;
  logic [3:0]   addr_out;
  logic [6:0]   seg;
  logic [3:0]   an;
  logic         frame_tick;

  always #5 clock = ~clock;

  i281_datamem_display #(.SCAN_DIV(SD), .DWELL_FRAMES(DF)) dut (
    .clock       (clock),
    .reset       (reset),
    .datamem_flat(datamem_flat),
    .auto_mode   (auto_mode),
    .step        (step),
    .addr_out    (addr_out),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    logic       rst;
    logic       auto_m;
    logic       stp;
    logic [7:0] b0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [3:0] e_addr;
    logic       e_tick;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] hexv[16];
  logic [7:0] mem[16];
  logic [7:0] cur_b0;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic drive_mem();
    for (int k = 0; k < 16; k++) datamem_flat[k*8 +: 8] = mem[k];
  endtask

  task automatic add_reset(input logic am, input int n);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.rst = 1'b0; v.auto_m = am; v.stp = 1'b0; v.b0 = cur_b0;
      v.e_an = 4'b1111; v.e_seg = 7'b1111111; v.e_addr = 4'd0; v.e_tick = 1'b0;
      vecs.push_back(v);
    end
  endtask

  // Cycles first..last of a frame showing address a and byte d; 'after' is addr_out once the boundary edge hits.
  task automatic add_frame(input logic am, input logic [15:0] mask, input logic [3:0] a,
                           input logic [7:0] d, input logic [3:0] after, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      vec_t v;
      int   slot;
      slot     = (c - 1) / SD;
      v.rst    = 1'b1;
      v.auto_m = am;
      v.stp    = mask[c-1];
      v.b0     = cur_b0;
      case (slot)
        0:       begin v.e_an = 4'b0111; v.e_seg = hexv[a];      end
        1:       begin v.e_an = 4'b1111; v.e_seg = 7'b1111111;   end
        2:       begin v.e_an = 4'b1101; v.e_seg = hexv[d[7:4]]; end
        default: begin v.e_an = 4'b1110; v.e_seg = hexv[d[3:0]]; end
      endcase
      v.e_addr = (c == FL) ? after : a;
      v.e_tick = (c == FL);
      vecs.push_back(v);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset     = v.rst;
    auto_mode = v.auto_m;
    step      = v.stp;
    mem[0]    = v.b0;
    drive_mem();
    @(posedge clock);
    #1;
    n_vec++;
    if (an !== v.e_an) begin
      n_bad++;
      $display("FAIL vec %0d an: got %b want %b", idx, an, v.e_an);
    end
    if (seg !== v.e_seg) begin
      n_bad++;
      $display("FAIL vec %0d seg: got %b want %b", idx, seg, v.e_seg);
    end
    if (addr_out !== v.e_addr) begin
      n_bad++;
      $display("FAIL vec %0d addr_out: got %h want %h", idx, addr_out, v.e_addr);
    end
    if (frame_tick !== v.e_tick) begin
      n_bad++;
      $display("FAIL vec %0d frame_tick: got %b want %b", idx, frame_tick, v.e_tick);
    end
  endtask

  initial begin
    int gap;
    hexv[0]  = 7'b1000000; hexv[1]  = 7'b1111001; hexv[2]  = 7'b0100100; hexv[3]  = 7'b0110000;
    hexv[4]  = 7'b0011001; hexv[5]  = 7'b0010010; hexv[6]  = 7'b0000010; hexv[7]  = 7'b1111000;
    hexv[8]  = 7'b0000000; hexv[9]  = 7'b0010000; hexv[10] = 7'b0001000; hexv[11] = 7'b0000011;
    hexv[12] = 7'b1000110; hexv[13] = 7'b0100001; hexv[14] = 7'b0000110; hexv[15] = 7'b0001110;

    for (int k = 0; k < 16; k++) mem[k] = 8'h00;
    mem[0] = 8'h3C; mem[3] = 8'hA5; mem[7] = 8'h4D; mem[11] = 8'h96; mem[15] = 8'h0F;
    cur_b0    = 8'h3C;
    reset     = 1'b0;
    auto_mode = 1'b0;
    step      = 1'b0;
    drive_mem();

    add_reset(1'b0, 3);
    add_frame(1'b0, 16'h0000, 4'h0, 8'h3C, 4'h0, 1, FL);  // first frame after release: '0', blank, '3', 'C'
    add_frame(1'b0, 16'h002A, 4'h0, 8'h3C, 4'h3, 1, FL);  // three step pulses accumulate to address 3
    add_frame(1'b0, 16'h5555, 4'h3, 8'hA5, 4'hB, 1, FL);  // shows 3/A5; eight more pulses -> 11
    add_frame(1'b0, 16'h0055, 4'hB, 8'h96, 4'hF, 1, FL);  // shows B/96; four pulses -> 15
    add_frame(1'b1, 16'h0555, 4'hF, 8'h0F, 4'hF, 1, FL);  // auto: steps ignored, dwell 0->1
    add_frame(1'b1, 16'h0000, 4'hF, 8'h0F, 4'hF, 1, FL);  // dwell expires, next_addr wraps 15->0
    cur_b0 = 8'h11;
    add_frame(1'b1, 16'h0000, 4'hF, 8'h0F, 4'h0, 1, FL);  // wrapped address becomes visible
    add_frame(1'b0, 16'h0000, 4'h0, 8'h11, 4'h0, 1, 9);   // byte0 0x11 snapshotted
    cur_b0 = 8'h22;                                        // write lands mid slot 2
    add_frame(1'b0, 16'h0000, 4'h0, 8'h11, 4'h0, 10, FL); // still '1','1' for the rest of the frame
    add_frame(1'b0, 16'h1555, 4'h0, 8'h22, 4'h7, 1, FL);  // new byte shown; seven pulses -> 7
    add_frame(1'b1, 16'h0000, 4'h7, 8'h4D, 4'h7, 1, 6);   // auto at address 7, cut short
    add_reset(1'b1, 2);                                    // mid-slot reset clears outputs on that edge
    add_frame(1'b0, 16'h0000, 4'h0, 8'h22, 4'h0, 1, FL);  // load flag: address 0 visible immediately

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Boundary-to-boundary spacing must be one full frame.
    reset = 1'b1; auto_mode = 1'b0; step = 1'b0;
    gap = 0;
    for (int i = 1; i <= 3 * FL; i++) begin
      @(posedge clock);
      #1;
      if (frame_tick === 1'b1) begin
        gap = i;
        break;
      end
    end
    n_vec++;
    if (gap != FL) begin
      n_bad++;
      $display("FAIL tick_period: got %0d want %0d", gap, FL);
    end
    @(posedge clock);
    #1;
    n_vec++;
    if (an !== 4'b0111 || seg !== hexv[0] || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL post_tick_slot0: got an=%b seg=%b tick=%b want an=0111 seg=%b tick=0",
               an, seg, frame_tick, hexv[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
